// File: rtl/screensaver_motion_ctrl.sv
// Per-frame motion scheduler for the bouncing screensaver sprite: detects the first
// blanking line, steps X then Y with edge bounce, commits, and flags the sprite window.
module screensaver_motion_ctrl #(
  parameter int H_DISPLAY = 640,
  parameter int V_DISPLAY = 480,
  parameter int SPRITE_W  = 64,
  parameter int SPRITE_H  = 32,
  localparam int UW = $clog2(SPRITE_W),
  localparam int VW = $clog2(SPRITE_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [9:0]    hpos,
  input  logic [9:0]    vpos,
  input  logic          display_on,
  input  logic          enable,
  input  logic [2:0]    speed,
  output logic [9:0]    x_pos,
  output logic [9:0]    y_pos,
  output logic          sprite_on,
  output logic [UW-1:0] sprite_u,
  output logic [VW-1:0] sprite_v,
  output logic [2:0]    color_idx,
  output logic          bounce,
  output logic [7:0]    corner_cnt
);

  typedef enum logic [1:0] {S_WAIT, S_X, S_Y, S_COMMIT} state_t;

  typedef struct packed {
    logic [9:0] pos;
    logic       hit;
  } step_t;

  localparam logic [10:0] X_LIM  = 11'(H_DISPLAY - SPRITE_W);
  localparam logic [10:0] Y_LIM  = 11'(V_DISPLAY - SPRITE_H);
  localparam logic [10:0] W_EXT  = 11'(SPRITE_W);
  localparam logic [10:0] H_EXT  = 11'(SPRITE_H);
  localparam logic [9:0]  V_TICK = 10'(V_DISPLAY);

  state_t     state, state_next;
  logic       tick;
  logic [2:0] spd;
  logic       dir_x, dir_y;
  logic       hit_x, hit_y;
  logic [9:0] nx, ny;
  step_t      x_step, y_step;
  logic       in_win;

  // One axis step in 11-bit arithmetic; fwd=1 means moving towards the limit.
  function automatic step_t axis_step(input logic [9:0] pos, input logic [2:0] s,
                                      input logic fwd, input logic [10:0] lim);
    logic [10:0] p_ext;
    logic [10:0] s_ext;
    step_t       r;
    p_ext = {1'b0, pos};
    s_ext = {8'b0, s};
    r.pos = pos;
    r.hit = 1'b0;
    if (fwd) begin
      if (p_ext + s_ext >= lim) begin
        r.pos = lim[9:0];
        r.hit = 1'b1;
      end else begin
        r.pos = pos + {7'b0, s};
      end
    end else if (p_ext < s_ext) begin
      r.pos = '0;
      r.hit = 1'b1;
    end else begin
      r.pos = pos - {7'b0, s};
    end
    return r;
  endfunction

  assign x_step = axis_step(x_pos, spd, dir_x, X_LIM);
  assign y_step = axis_step(y_pos, spd, dir_y, Y_LIM);

  assign in_win = display_on
               && ({1'b0, hpos} >= {1'b0, x_pos}) && ({1'b0, hpos} < {1'b0, x_pos} + W_EXT)
               && ({1'b0, vpos} >= {1'b0, y_pos}) && ({1'b0, vpos} < {1'b0, y_pos} + H_EXT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick  <= 1'b0;
      state <= S_WAIT;
    end else begin
      tick  <= (hpos == 10'd0) && (vpos == V_TICK);
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_WAIT:   if (tick && enable) state_next = S_X;
      S_X:      state_next = S_Y;
      S_Y:      state_next = S_COMMIT;
      S_COMMIT: state_next = S_WAIT;
      default:  state_next = S_WAIT;
    endcase
  end

  // Directions flip as soon as an axis is evaluated; a reset mid-sequence clears them anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spd        <= '0;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      hit_x      <= 1'b0;
      hit_y      <= 1'b0;
      nx         <= '0;
      ny         <= '0;
      x_pos      <= '0;
      y_pos      <= '0;
      color_idx  <= '0;
      corner_cnt <= '0;
      bounce     <= 1'b0;
    end else begin
      bounce <= 1'b0;
      case (state)
        S_WAIT: if (tick && enable) spd <= speed;
        S_X: begin
          nx    <= x_step.pos;
          hit_x <= x_step.hit;
          if (x_step.hit) dir_x <= ~dir_x;
        end
        S_Y: begin
          ny    <= y_step.pos;
          hit_y <= y_step.hit;
          if (y_step.hit) dir_y <= ~dir_y;
        end
        S_COMMIT: begin
          x_pos  <= nx;
          y_pos  <= ny;
          bounce <= hit_x | hit_y;
          if (hit_x | hit_y) color_idx  <= color_idx + 3'd1;
          if (hit_x & hit_y) corner_cnt <= corner_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sprite_on <= 1'b0;
      sprite_u  <= '0;
      sprite_v  <= '0;
    end else begin
      sprite_on <= in_win;
      sprite_u  <= in_win ? (UW'(hpos) - UW'(x_pos)) : '0;
      sprite_v  <= in_win ? (VW'(vpos) - VW'(y_pos)) : '0;
    end
  end

endmodule

// File: tb/tb_screensaver_motion_ctrl.sv
// Directed bench for screensaver_motion_ctrl: frame ticks driven directly on hpos/vpos,
// plus a second instance with equal X/Y limits for the corner case.
module tb_screensaver_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] hpos = 10'd1;
  logic [9:0] vpos = 10'd500;
  logic       display_on = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] speed = 3'd0;

  logic [9:0] x_pos, y_pos, x_pos2, y_pos2;
  logic       sprite_on, sprite_on2, bounce, bounce2;
  logic [5:0] sprite_u;
  logic [4:0] sprite_v, sprite_u2, sprite_v2;
  logic [2:0] color_idx, color_idx2;
  logic [7:0] corner_cnt, corner_cnt2;

  int vectors = 0;
  int miscompares = 0;
  int bounce_cnt = 0;
  int bounce_cnt2 = 0;

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic       de;
    int         on;
    int         u;
    int         vv;
  } sprite_vec_t;

  sprite_vec_t tab_a[9];
  sprite_vec_t tab_b[6];

  screensaver_motion_ctrl dut (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .enable(enable), .speed(speed), .x_pos(x_pos), .y_pos(y_pos), .sprite_on(sprite_on),
    .sprite_u(sprite_u), .sprite_v(sprite_v), .color_idx(color_idx), .bounce(bounce),
    .corner_cnt(corner_cnt)
  );

  screensaver_motion_ctrl #(.H_DISPLAY(64), .V_DISPLAY(64), .SPRITE_W(32), .SPRITE_H(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .enable(enable), .speed(speed), .x_pos(x_pos2), .y_pos(y_pos2), .sprite_on(sprite_on2),
    .sprite_u(sprite_u2), .sprite_v(sprite_v2), .color_idx(color_idx2), .bounce(bounce2),
    .corner_cnt(corner_cnt2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && bounce)  bounce_cnt++;
    if (rst_n && bounce2) bounce_cnt2++;
  end

  task automatic check_output(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input sprite_vec_t t);
    @(negedge clk);
    hpos = t.h;
    vpos = t.v;
    display_on = t.de;
    @(negedge clk);
    check_output("sprite_on", int'(sprite_on), t.on);
    check_output("sprite_u", int'(sprite_u), t.u);
    check_output("sprite_v", int'(sprite_v), t.vv);
  endtask

  // Tick line held for 'hold' cycles, then enough idle cycles for the commit to land.
  task automatic run_frame(input int vd, input int hold);
    @(negedge clk);
    hpos = 10'd0;
    vpos = 10'(vd);
    repeat (hold) @(negedge clk);
    hpos = 10'd1;
    vpos = 10'd500;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey, input int ec,
                           input int ek, input int eb);
    check_output({tag, " x_pos"}, int'(x_pos), ex);
    check_output({tag, " y_pos"}, int'(y_pos), ey);
    check_output({tag, " color_idx"}, int'(color_idx), ec);
    check_output({tag, " corner_cnt"}, int'(corner_cnt), ek);
    check_output({tag, " bounce pulses"}, bounce_cnt, eb);
  endtask

  initial begin
    tab_a[0] = '{10'd1,  10'd1,  1'b1, 1, 0,  0};
    tab_a[1] = '{10'd0,  10'd1,  1'b1, 0, 0,  0};
    tab_a[2] = '{10'd64, 10'd1,  1'b1, 1, 63, 0};
    tab_a[3] = '{10'd65, 10'd1,  1'b1, 0, 0,  0};
    tab_a[4] = '{10'd10, 10'd32, 1'b1, 1, 9,  31};
    tab_a[5] = '{10'd10, 10'd33, 1'b1, 0, 0,  0};
    tab_a[6] = '{10'd10, 10'd0,  1'b1, 0, 0,  0};
    tab_a[7] = '{10'd10, 10'd10, 1'b0, 0, 0,  0};
    tab_a[8] = '{10'd30, 10'd20, 1'b1, 1, 29, 19};

    tab_b[0] = '{10'd455, 10'd441, 1'b1, 1, 0,  0};
    tab_b[1] = '{10'd454, 10'd441, 1'b1, 0, 0,  0};
    tab_b[2] = '{10'd518, 10'd472, 1'b1, 1, 63, 31};
    tab_b[3] = '{10'd519, 10'd441, 1'b1, 0, 0,  0};
    tab_b[4] = '{10'd460, 10'd473, 1'b1, 0, 0,  0};
    tab_b[5] = '{10'd460, 10'd450, 1'b0, 0, 0,  0};

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_pos("reset", 0, 0, 0, 0, 0);
    check_output("reset sprite_on", int'(sprite_on), 0);
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    speed = 3'd1;

    // First frame: x/y must change exactly four edges after hpos=0,vpos=480 is sampled.
    @(negedge clk);
    hpos = 10'd0;
    vpos = 10'd480;
    @(negedge clk);
    hpos = 10'd1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_output($sformatf("latency x_pos edge %0d", k), int'(x_pos), 0);
    end
    @(negedge clk);
    vpos = 10'd500;
    check_pos("frame1", 1, 1, 0, 0, 0);

    for (int i = 0; i < 9; i++) apply_stimulus(tab_a[i]);
    display_on = 1'b0;

    enable = 1'b0;
    speed = 3'd3;
    for (int f = 0; f < 5; f++) run_frame(480, 1);
    check_pos("enable=0", 1, 1, 0, 0, 0);
    enable = 1'b1;
    speed = 3'd0;
    for (int f = 0; f < 5; f++) run_frame(480, 1);
    check_pos("speed=0", 1, 1, 0, 0, 0);

    speed = 3'd2;
    run_frame(480, 2);
    check_pos("double tick", 3, 3, 0, 0, 0);

    // speed/enable changed after the latch edge must not affect this frame.
    @(negedge clk);
    hpos = 10'd0;
    vpos = 10'd480;
    @(negedge clk);
    hpos = 10'd1;
    vpos = 10'd500;
    @(negedge clk);
    speed = 3'd5;
    enable = 1'b0;
    repeat (5) @(negedge clk);
    check_pos("mid-sequence change", 5, 5, 0, 0, 0);
    enable = 1'b1;
    speed = 3'd7;

    // Reset asserted while the FSM is in S_Y.
    @(negedge clk);
    hpos = 10'd0;
    vpos = 10'd480;
    @(negedge clk);
    hpos = 10'd1;
    vpos = 10'd500;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("async reset x_pos", int'(x_pos), 0);
    check_output("async reset y_pos", int'(y_pos), 0);
    check_output("async reset bounce", int'(bounce), 0);
    check_output("async reset sprite_on", int'(sprite_on), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_pos("after reset no commit", 0, 0, 0, 0, 0);

    run_frame(480, 1);
    check_pos("speed7 frame1", 7, 7, 0, 0, 0);
    for (int f = 2; f <= 63; f++) run_frame(480, 1);
    check_pos("speed7 frame63", 441, 441, 0, 0, 0);
    run_frame(480, 1);
    check_pos("speed7 frame64", 448, 448, 1, 0, 1);
    run_frame(480, 1);
    check_pos("speed7 frame65", 455, 441, 1, 0, 1);

    for (int i = 0; i < 6; i++) apply_stimulus(tab_b[i]);
    display_on = 1'b0;

    speed = 3'd1;
    for (int f = 1; f <= 31; f++) run_frame(64, 1);
    check_output("corner frame31 x", int'(x_pos2), 31);
    check_output("corner frame31 y", int'(y_pos2), 31);
    check_output("corner frame31 corner_cnt", int'(corner_cnt2), 0);
    run_frame(64, 1);
    check_output("corner frame32 x", int'(x_pos2), 32);
    check_output("corner frame32 y", int'(y_pos2), 32);
    check_output("corner frame32 corner_cnt", int'(corner_cnt2), 1);
    check_output("corner frame32 color_idx", int'(color_idx2), 1);
    check_output("corner frame32 bounce pulses", bounce_cnt2, 1);
    run_frame(64, 1);
    check_output("corner frame33 x", int'(x_pos2), 31);
    check_output("corner frame33 y", int'(y_pos2), 31);
    check_output("corner frame33 color_idx", int'(color_idx2), 1);
    check_output("main dut untouched x", int'(x_pos), 455);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
